arbiter_rr_pkt: RTL

//  N-input, one-output valid/ready arbiter with selectable fixed or round-robin priority.

---
 rtl/arbiter_pkg.sv | 25 ++
 rtl/arbitration_logic_rr.sv | 36 +++
 rtl/arbiter_rr_pkt.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the packet-locking valid/ready arbiter.
package arbiter_pkg;

  // Priority scheme: index 0 always highest, or rotating after each grant.
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  // Packet lock state: IDLE re-arbitrates, HELD keeps the grant on lock_id.
  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_t;

  // Width of a channel index for n channels (n >= 2).
  function automatic int idw_of(input int n);
    return $clog2(n);
  endfunction

  // Index of the set bit of a one-hot (or zero) vector; zero input gives 0.
  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitration_logic_rr.sv
// Rotating-priority grant: first request at or after ptr, searching upward
// modulo N. Tying ptr to 0 turns it into a fixed lowest-index-wins encoder.
module arbitration_logic_rr
  import arbiter_pkg::*;
#(
  parameter int  N   = 2,
  localparam int IDW = idw_of(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] masked;
  logic           found;

  // Double the request vector, mask off bits below ptr, and take the first
  // set bit; the upper copy provides the wrap-around past N-1.
  always_comb begin
    dreq   = {req, req};
    masked = '0;
    grant  = '0;
    found  = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dreq[i] & (i >= int'(ptr));
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (masked[i] && !found) begin
        found        = 1'b1;
        grant[i % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_pkt.sv
// N-to-1 valid/ready arbiter with optional packet lock and a registered
// output stage. Handshake: a beat moves on a side when valid and ready are
// both high in the same cycle; senders hold valid/data until accepted, and
// in_ready never depends on the valid of a channel other than the granted one.
module arbiter_rr_pkt
  import arbiter_pkg::*;
#(
  parameter int        DWIDTH   = 8,
  parameter int        N        = 2,
  parameter arb_mode_t MODE     = ARB_RR,
  parameter bit        PKT_LOCK = 1'b1,
  localparam int       IDW      = idw_of(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  input  logic              in_last  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  logic [N-1:0]      req;
  logic [N-1:0]      arb_grant;
  logic [N-1:0]      grant;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    arb_ptr;
  logic [IDW-1:0]    lock_id;
  logic [IDW-1:0]    lock_id_next;
  logic [IDW-1:0]    gnt_idx;
  logic [DWIDTH-1:0] sel_data;
  logic              sel_last;
  logic              can_load;
  logic              xfer;
  lock_state_t       lock_state;
  lock_state_t       lock_next;

  // Fixed priority is rotating priority with the pointer pinned at 0.
  assign arb_ptr  = (MODE == ARB_RR) ? ptr : '0;
  assign can_load = !out_valid || out_ready;

  arbitration_logic_rr #(.N(N)) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .grant (arb_grant)
  );

  // Final grant: locked channel only while a packet is open, otherwise the
  // arbiter's choice; AND-OR mux of data/last over the one-hot grant.
  always_comb begin
    grant    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = in_valid[i];
    end
    if (PKT_LOCK && lock_state == LOCK_HELD) begin
      for (int i = 0; i < N; i++) begin
        grant[i] = req[i] && (lock_id == IDW'(i));
      end
    end else begin
      grant = arb_grant;
    end
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | ({DWIDTH{grant[i]}} & in_data[i]);
      sel_last = sel_last | (grant[i] & in_last[i]);
    end
  end

  assign gnt_idx = IDW'(onehot2idx(32'(grant)));
  assign xfer    = (|grant) && can_load && !rst;

  // Per-channel ready: only the granted channel, only when the stage can load.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = grant[i] && can_load && !rst;
    end
  end

  // Output stage: load on transfer, otherwise drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_id    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Rotating pointer: move past the served channel, at packet end when locking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == ARB_RR && xfer && (!PKT_LOCK || sel_last)) begin
      ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= LOCK_IDLE;
      lock_id    <= '0;
    end else begin
      lock_state <= lock_next;
      lock_id    <= lock_id_next;
    end
  end

  // Lock next-state: open on a non-last beat, close on the last beat of the
  // locked channel; single-beat packets never lock.
  always_comb begin
    lock_next    = lock_state;
    lock_id_next = lock_id;
    if (PKT_LOCK) begin
      case (lock_state)
        LOCK_IDLE: begin
          if (xfer && !sel_last) begin
            lock_next    = LOCK_HELD;
            lock_id_next = gnt_idx;
          end
        end
        LOCK_HELD: begin
          if (xfer && sel_last) lock_next = LOCK_IDLE;
        end
        default: lock_next = LOCK_IDLE;
      endcase
    end else begin
      lock_next = LOCK_IDLE;
    end
  end

endmodule
